dmem_arbiter: RTL and testbench

Shares the single-port, word-addressed data memory between two requesters: the core load/store unit (`c_*`) and the program/scene loader (`l_*`). It sequences every access through a small FSM and converts byte addresses to word indices. It performs read-modify-write for byte and halfword stores, extracts byte and halfword lanes on loads, and rejects misaligned or out-of-range accesses. The block sits between the core's memory stage and the memory array's `addr`, `should_write`, `write_data` and `read_data` ports.

---
 rtl/dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares one single-port, word-addressed data memory between the core
// load/store unit (c_*) and the program/scene loader (l_*). Each access is
// sequenced by a small FSM. Byte and halfword stores are done as a
// read-modify-write. Loads return the addressed lane, right-aligned and
// zero-extended. Misaligned, out-of-range and illegal-size accesses are
// rejected with err.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   c_req / l_req          request, held with stable fields until ack
//   c_we / l_we            1 = store, 0 = load
//   c_addr / l_addr        byte address
//   c_size / l_size        0 = byte, 1 = half, 2 = word, 3 = illegal
//   c_wdata / l_wdata      right-aligned store data
//   c_ack / l_ack          one-cycle completion pulse
//   c_err / l_err          with ack: access was rejected
//   c_rdata / l_rdata      load result while ack is high, 0 otherwise
//   mem_addr               word index into the memory
//   mem_write              write strobe (memory commits on the falling edge)
//   mem_wdata              full word to write
//   mem_rdata              combinational read data for mem_addr
//
// Every output is registered. Latency from the edge that samples a request
// to the ack cycle is 2 edges for a load, 3 for a store and 1 for an error.
// The ack pulse overlaps IDLE, so IDLE resamples at the edge that ends the
// ack cycle.

module dmem_arbiter #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_size,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rdata,

    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [1:0]  l_size,
    input  logic [31:0] l_wdata,
    output logic        l_ack,
    output logic        l_err,
    output logic [31:0] l_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StWrite,
        StResp,
        StErr
    } state_e;

    localparam logic GrantCore   = 1'b0;
    localparam logic GrantLoader = 1'b1;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    // Only the lane bits are kept; the word index lives in mem_addr_q.
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        c_ack_q, c_ack_d;
    logic        c_err_q, c_err_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic        l_ack_q, l_ack_d;
    logic        l_err_q, l_err_d;
    logic [31:0] l_rdata_q, l_rdata_d;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    logic        pick;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic [31:0] sel_wdata;
    logic        sel_illegal;

    always_comb begin
        pick = GrantCore;
        if (c_req && l_req) begin
            pick = (last_grant_q == GrantLoader) ? GrantCore : GrantLoader;
        end else if (l_req) begin
            pick = GrantLoader;
        end

        sel_we    = (pick == GrantLoader) ? l_we    : c_we;
        sel_addr  = (pick == GrantLoader) ? l_addr  : c_addr;
        sel_size  = (pick == GrantLoader) ? l_size  : c_size;
        sel_wdata = (pick == GrantLoader) ? l_wdata : c_wdata;

        sel_illegal = 1'b0;
        unique case (sel_size)
            SizeByte: sel_illegal = 1'b0;
            SizeHalf: sel_illegal = sel_addr[0];
            SizeWord: sel_illegal = (sel_addr[1:0] != 2'b00);
            default:  sel_illegal = 1'b1;
        endcase
        if ({2'b00, sel_addr[31:2]} >= MEM_WORDS) begin
            sel_illegal = 1'b1;
        end
    end

    // Store merge: the addressed lane(s) replaced inside the word just read.
    logic [31:0] merged;

    always_comb begin
        merged = mem_rdata;
        unique case (size_q)
            SizeByte: merged[{lane_q, 3'b000} +: 8]         = wdata_q[7:0];
            SizeHalf: merged[{lane_q[1], 4'b0000} +: 16]    = wdata_q[15:0];
            default:  merged                                = wdata_q;
        endcase
    end

    // Load extraction from the captured word.
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        shifted = rbuf_q >> {lane_q, 3'b000};
        unique case (size_q)
            SizeByte: load_data = {24'h000000, shifted[7:0]};
            SizeHalf: load_data = {16'h0000, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        size_d       = size_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        mem_addr_d   = mem_addr_q;
        mem_write_d  = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        c_ack_d      = 1'b0;
        c_err_d      = 1'b0;
        c_rdata_d    = 32'h0;
        l_ack_d      = 1'b0;
        l_err_d      = 1'b0;
        l_rdata_d    = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (c_req || l_req) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    we_d         = sel_we;
                    size_d       = sel_size;
                    lane_d       = sel_addr[1:0];
                    wdata_d      = sel_wdata;
                    if (sel_illegal) begin
                        state_d = StErr;
                    end else begin
                        // Presented here so the memory read is valid during ACCESS.
                        mem_addr_d = {2'b00, sel_addr[31:2]};
                        state_d    = StAccess;
                    end
                end
            end

            StAccess: begin
                rbuf_d = mem_rdata;
                if (we_q) begin
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                    state_d     = StWrite;
                end else begin
                    state_d = StResp;
                end
            end

            StWrite: begin
                state_d = StResp;
            end

            StResp: begin
                if (gnt_q == GrantLoader) begin
                    l_ack_d   = 1'b1;
                    l_rdata_d = we_q ? 32'h0 : load_data;
                end else begin
                    c_ack_d   = 1'b1;
                    c_rdata_d = we_q ? 32'h0 : load_data;
                end
                state_d = StIdle;
            end

            StErr: begin
                if (gnt_q == GrantLoader) begin
                    l_ack_d = 1'b1;
                    l_err_d = 1'b1;
                end else begin
                    c_ack_d = 1'b1;
                    c_err_d = 1'b1;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantLoader;
            gnt_q        <= GrantCore;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            rbuf_q       <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= 32'h0;
            c_ack_q      <= 1'b0;
            c_err_q      <= 1'b0;
            c_rdata_q    <= 32'h0;
            l_ack_q      <= 1'b0;
            l_err_q      <= 1'b0;
            l_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            mem_addr_q   <= mem_addr_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
            c_ack_q      <= c_ack_d;
            c_err_q      <= c_err_d;
            c_rdata_q    <= c_rdata_d;
            l_ack_q      <= l_ack_d;
            l_err_q      <= l_err_d;
            l_rdata_q    <= l_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
    assign c_ack     = c_ack_q;
    assign c_err     = c_err_q;
    assign c_rdata   = c_rdata_q;
    assign l_ack     = l_ack_q;
    assign l_err     = l_err_q;
    assign l_rdata   = l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a behavioural memory plus a byte-lane model
// predict every response and every memory write; monitors pop and compare.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic [1:0]  c_size, l_size;
    logic        c_ack, c_err, l_ack, l_err;
    logic [31:0] c_rdata, l_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_size    (c_size),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack),
        .c_err     (c_err),
        .c_rdata   (c_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_size    (l_size),
        .l_wdata   (l_wdata),
        .l_ack     (l_ack),
        .l_err     (l_err),
        .l_rdata   (l_rdata),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural memory: combinational read, commit on the falling edge.
    logic [31:0] mem [0:1023];
    bit          mem_init_done;

    assign mem_rdata = (mem_addr[31:10] == 22'h0) ? mem[mem_addr[9:0]] : 32'h0;

    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboards
    typedef struct packed {
        logic        who;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    logic [31:0] model_mem [0:1023];

    resp_t mon_r;
    wr_t   mon_w;

    always @(negedge clk) begin
        if (c_ack || l_ack) begin
            check("dual_ack", {31'b0, c_ack & l_ack}, 32'h0);
            if (resp_q.size() == 0) begin
                check("unexpected_ack", {30'b0, c_ack, l_ack}, 32'h0);
            end else begin
                mon_r = resp_q.pop_front();
                check("ack_who", {31'b0, l_ack}, {31'b0, mon_r.who});
                check("ack_err", {31'b0, (mon_r.who ? l_err : c_err)}, {31'b0, mon_r.err});
                check("ack_rdata", mon_r.who ? l_rdata : c_rdata, mon_r.rdata);
            end
        end
        if (mem_write) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", {31'b0, mem_write}, 32'h0);
            end else begin
                mon_w = wr_q.pop_front();
                check("wr_addr", mem_addr, mon_w.addr);
                check("wr_data", mem_wdata, mon_w.data);
            end
        end
    end

    // Byte-lane reference model
    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        case (size)
            2'd0: b[lane] = wd[7:0];
            2'd1: begin
                b[{lane[1], 1'b0}] = wd[7:0];
                b[{lane[1], 1'b1}] = wd[15:8];
            end
            default: for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
        endcase
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        case (size)
            2'd0:    return {24'h0, b[lane]};
            2'd1:    return {16'h0, b[{lane[1], 1'b1}], b[{lane[1], 1'b0}]};
            default: return w;
        endcase
    endfunction

    function automatic bit model_illegal(input logic [31:0] a, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && a[0]) ||
               (size == 2'd2 && a[1:0] != 2'b00) || (a[31:12] != 20'h0);
    endfunction

    task automatic drive(input bit who, input bit req, input bit we, input logic [31:0] a,
                         input logic [1:0] size, input logic [31:0] wd);
        if (who) begin
            l_req = req; l_we = we; l_addr = a; l_size = size; l_wdata = wd;
        end else begin
            c_req = req; c_we = we; c_addr = a; c_size = size; c_wdata = wd;
        end
    endtask

    // Called just after a rising edge with req already driven; the next
    // edge samples. Ack is expected after edge N+lat, i.e. on cycle lat+1.
    task automatic wait_ack(input bit who, input int lat, input string tag);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (who ? l_ack : c_ack) seen = 1;
        end
        check(tag, cyc, lat + 1);
    endtask

    // Predict and queue the outcome of one access (updates the model).
    task automatic predict(input bit who, input bit we, input logic [31:0] a,
                           input logic [1:0] size, input logic [31:0] wd, output int lat);
        resp_t r;
        wr_t   w;
        r.who   = who;
        r.err   = model_illegal(a, size);
        r.rdata = 32'h0;
        if (r.err) begin
            lat = 1;
        end else if (we) begin
            w.addr = {2'b00, a[31:2]};
            w.data = model_store(model_mem[a[11:2]], a[1:0], size, wd);
            model_mem[a[11:2]] = w.data;
            wr_q.push_back(w);
            lat = 3;
        end else begin
            r.rdata = model_load(model_mem[a[11:2]], a[1:0], size);
            lat = 2;
        end
        resp_q.push_back(r);
    endtask

    task automatic access(input bit who, input bit we, input logic [31:0] a,
                          input logic [1:0] size, input logic [31:0] wd, input string tag);
        int lat;
        predict(who, we, a, size, wd, lat);
        drive(who, 1'b1, we, a, size, wd);
        wait_ack(who, lat, tag);
        drive(who, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    endtask

    initial begin
        int lat;
        int cyc;
        int acks;
        logic [31:0] old6;

        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_c_ack", {31'b0, c_ack}, 32'h0);
        check("rst_l_ack", {31'b0, l_ack}, 32'h0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        #1 reset = 1'b0;

        // Word store then load
        access(1'b0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, "lat_st_word");
        access(1'b0, 1'b0, 32'h10, 2'd2, 32'h0, "lat_ld_word");

        // Sub-word lanes
        access(1'b0, 1'b1, 32'h10, 2'd2, 32'h11223344, "lat_st_pre");
        access(1'b0, 1'b1, 32'h13, 2'd0, 32'hFFFFFFAA, "lat_st_byte");
        check("mem_byte_st", mem[4], 32'hAA223344);
        access(1'b1, 1'b0, 32'h12, 2'd0, 32'h0, "lat_ld_byte");
        access(1'b1, 1'b1, 32'h10, 2'd1, 32'h1234BEEF, "lat_st_half");
        check("mem_half_st", mem[4], 32'hAA22BEEF);
        access(1'b0, 1'b0, 32'h12, 2'd1, 32'h0, "lat_ld_half");
        access(1'b1, 1'b1, 32'h14, 2'd2, 32'h55667788, "lat_st_l");

        // Rejected accesses
        access(1'b0, 1'b0, 32'h01, 2'd1, 32'h0, "lat_err_half");
        access(1'b1, 1'b1, 32'h1002, 2'd2, 32'hCAFEF00D, "lat_err_misal");
        access(1'b0, 1'b1, 32'h1000, 2'd2, 32'hCAFEF00D, "lat_err_range");
        access(1'b1, 1'b0, 32'h20, 2'd3, 32'h0, "lat_err_size");
        check("mem_err_w4", mem[4], 32'hAA22BEEF);
        check("mem_err_w0", mem[0], model_mem[0]);

        // Round-robin under continuous contention, right after reset
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            predict(1'b0, 1'b0, 32'h10, 2'd2, 32'h0, lat);
            predict(1'b1, 1'b0, 32'h14, 2'd2, 32'h0, lat);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h14, 2'd2, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        cyc  = 0;
        acks = 0;
        while (acks < 6 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (c_ack || l_ack) acks++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        check("rr_acks", acks, 6);
        check("rr_cycles", cyc, 18);

        // Reset while in ACCESS aborts a loader byte store
        @(posedge clk);
        #1;
        old6 = model_mem[6];
        predict(1'b1, 1'b1, 32'h19, 2'd0, 32'h0000005A, lat);
        drive(1'b1, 1'b1, 1'b1, 32'h19, 2'd0, 32'h0000005A);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_write", {31'b0, mem_write}, 32'h0);
        check("abort_ack", {31'b0, l_ack}, 32'h0);
        @(posedge clk);
        #2;
        check("abort_mem", mem[6], old6);
        reset = 1'b0;
        wait_ack(1'b1, lat, "lat_after_reset");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        check("mem_after_reset", mem[6], model_mem[6]);

        // Core load held across its ack: two loads in 6 cycles
        predict(1'b0, 1'b0, 32'h18, 2'd2, 32'h0, lat);
        predict(1'b0, 1'b0, 32'h18, 2'd2, 32'h0, lat);
        drive(1'b0, 1'b1, 1'b0, 32'h18, 2'd2, 32'h0);
        cyc  = 0;
        acks = 0;
        while (acks < 2 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (c_ack) acks++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        check("held_cycles", cyc, 6);

        repeat (6) @(posedge clk);
        #1;
        check("resp_drain", resp_q.size(), 0);
        check("wr_drain", wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
